// File: rtl/alu16_seq_pkg.sv
// ============================================================================
// Module      : alu16_seq_pkg
// Description : Shared op codes and per-op decode for the sequential ALU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu16_seq_pkg;

    // 8-bit ALU core operations
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_AND = 3'd1;
    localparam logic [2:0] ALU_OR  = 3'd2;
    localparam logic [2:0] ALU_XOR = 3'd3;
    localparam logic [2:0] ALU_SHL = 3'd4;
    localparam logic [2:0] ALU_SHR = 3'd5;

    typedef enum logic [2:0] {
        SEQ_ADD = 3'd0,
        SEQ_SUB = 3'd1,
        SEQ_CMP = 3'd2,
        SEQ_AND = 3'd3,
        SEQ_OR  = 3'd4,
        SEQ_XOR = 3'd5,
        SEQ_SHL = 3'd6,
        SEQ_SHR = 3'd7
    } seq_op_t;

    typedef enum logic [1:0] {
        CIN_EXT  = 2'd0,
        CIN_ONE  = 2'd1,
        CIN_ZERO = 2'd2
    } cin_src_t;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       inv_b;
        logic       zero_b;
        cin_src_t   cin_src;
        logic       hi_first;
        logic       v_en;
    } seq_ctl_t;

    function automatic seq_ctl_t seq_decode(input seq_op_t op);
        seq_ctl_t ctl;
        ctl = '{alu_op: ALU_ADD, inv_b: 1'b0, zero_b: 1'b0,
                cin_src: CIN_ZERO, hi_first: 1'b0, v_en: 1'b0};
        case (op)
            SEQ_ADD: begin ctl.cin_src = CIN_EXT; ctl.v_en = 1'b1; end
            SEQ_SUB: begin ctl.inv_b = 1'b1; ctl.cin_src = CIN_EXT; ctl.v_en = 1'b1; end
            SEQ_CMP: begin ctl.inv_b = 1'b1; ctl.cin_src = CIN_ONE; end
            SEQ_AND: ctl.alu_op = ALU_AND;
            SEQ_OR:  ctl.alu_op = ALU_OR;
            SEQ_XOR: ctl.alu_op = ALU_XOR;
            SEQ_SHL: begin ctl.alu_op = ALU_SHL; ctl.zero_b = 1'b1; ctl.cin_src = CIN_EXT; end
            SEQ_SHR: begin
                ctl.alu_op   = ALU_SHR;
                ctl.zero_b   = 1'b1;
                ctl.cin_src  = CIN_EXT;
                ctl.hi_first = 1'b1;
            end
            default: ctl.alu_op = ALU_ADD;
        endcase
        return ctl;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu16_seq_alu8.sv
// ============================================================================
// Module      : alu16_seq_alu8
// Description : 8-bit combinational ALU slice with carry and overflow out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu16_seq_alu8
    import alu16_seq_pkg::*;
(
    input  logic [2:0] i_op,
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic       i_ci,
    output logic [7:0] o_y,
    output logic       o_co,
    output logic       o_v
);

    logic [8:0] w_sum;

    assign w_sum = {1'b0, i_a} + {1'b0, i_b} + {8'd0, i_ci};

    always_comb begin
        o_y  = w_sum[7:0];
        o_co = 1'b0;
        o_v  = 1'b0;
        case (i_op)
            ALU_ADD: begin
                o_y  = w_sum[7:0];
                o_co = w_sum[8];
                // signed overflow: like-signed operands, different-signed sum
                o_v  = (i_a[7] == i_b[7]) && (w_sum[7] != i_a[7]);
            end
            ALU_AND: o_y = i_a & i_b;
            ALU_OR:  o_y = i_a | i_b;
            ALU_XOR: o_y = i_a ^ i_b;
            ALU_SHL: begin o_y = {i_a[6:0], i_ci}; o_co = i_a[7]; end
            ALU_SHR: begin o_y = {i_ci, i_a[7:1]}; o_co = i_a[0]; end
            default: o_y = w_sum[7:0];
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu16_seq.sv
// ============================================================================
// Module      : alu16_seq
// Description : 16-bit ALU built from two sequential passes of one 8-bit ALU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu16_seq
    import alu16_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  seq_op_t     op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        ci,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result,
    output logic        n,
    output logic        v,
    output logic        z,
    output logic        c
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        SECOND = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t      r_state, w_state_nxt;
    seq_op_t     r_op;
    logic [15:0] r_a, r_b, r_result;
    logic        r_ci, r_carry, r_n, r_v, r_z, r_c;

    seq_ctl_t    w_ctl;
    logic        w_take_hi;
    logic [7:0]  w_b_raw, w_alu_a, w_alu_b, w_alu_y;
    logic        w_alu_ci, w_alu_co, w_alu_v;
    logic [15:0] w_full;

    assign w_ctl = seq_decode(r_op);

    // SECOND always processes the byte FIRST did not
    assign w_take_hi = w_ctl.hi_first ^ (r_state == SECOND);

    always_comb begin
        w_alu_a = w_take_hi ? r_a[15:8] : r_a[7:0];
        w_b_raw = w_take_hi ? r_b[15:8] : r_b[7:0];
        w_alu_b = w_ctl.zero_b ? 8'h00 : (w_ctl.inv_b ? ~w_b_raw : w_b_raw);
        if (r_state == SECOND) begin
            w_alu_ci = r_carry;
        end else begin
            case (w_ctl.cin_src)
                CIN_EXT: w_alu_ci = r_ci;
                CIN_ONE: w_alu_ci = 1'b1;
                default: w_alu_ci = 1'b0;
            endcase
        end
    end

    alu16_seq_alu8 u_alu8 (
        .i_op (w_ctl.alu_op),
        .i_a  (w_alu_a),
        .i_b  (w_alu_b),
        .i_ci (w_alu_ci),
        .o_y  (w_alu_y),
        .o_co (w_alu_co),
        .o_v  (w_alu_v)
    );

    assign w_full = w_ctl.hi_first ? {r_result[15:8], w_alu_y} : {w_alu_y, r_result[7:0]};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_state_nxt = FIRST;
            FIRST:   w_state_nxt = SECOND;
            SECOND:  w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_op     <= SEQ_ADD;
            r_a      <= 16'h0000;
            r_b      <= 16'h0000;
            r_ci     <= 1'b0;
            r_carry  <= 1'b0;
            r_result <= 16'h0000;
            r_n      <= 1'b0;
            r_v      <= 1'b0;
            r_z      <= 1'b0;
            r_c      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: if (in_valid) begin
                    r_op <= op;
                    r_a  <= a;
                    r_b  <= b;
                    r_ci <= ci;
                end
                FIRST: begin
                    if (w_ctl.hi_first) r_result[15:8] <= w_alu_y;
                    else                r_result[7:0]  <= w_alu_y;
                    r_carry <= w_alu_co;
                end
                SECOND: begin
                    r_result <= w_full;
                    r_n      <= w_full[15];
                    r_z      <= (w_full == 16'h0000);
                    r_c      <= w_alu_co;
                    r_v      <= w_ctl.v_en & w_alu_v;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign result    = r_result;
    assign n         = r_n;
    assign v         = r_v;
    assign z         = r_z;
    assign c         = r_c;

endmodule

`default_nettype wire

// File: tb/tb_alu16_seq.sv
// ============================================================================
// Module      : tb_alu16_seq
// Description : Directed self-checking bench for alu16_seq.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu16_seq;
    import alu16_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    seq_op_t     op = SEQ_ADD;
    logic [15:0] a = 16'h0000;
    logic [15:0] b = 16'h0000;
    logic        ci = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] result;
    logic        n, v, z, c;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu16_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .n         (n),
        .v         (v),
        .z         (z),
        .c         (c)
    );

    // Issue one request, scramble inputs after accept, and count edges after
    // the accept edge until out_valid (2 => out_valid on the third edge).
    task automatic run_op(input seq_op_t o, input logic [15:0] aa, input logic [15:0] bb,
                          input logic cc, output int lat);
        int wait_cnt = 0;
        @(negedge clk);
        while (!in_ready && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        in_valid = 1'b1; op = o; a = aa; b = bb; ci = cc;
        @(posedge clk);
        #1;
        in_valid = 1'b0; op = SEQ_XOR; a = 16'hA5A5; b = 16'h5A5A; ci = ~cc;
        lat = 0;
        while (lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) break;
        end
    endtask

    task automatic finish_op();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if ({out_valid, result, n, v, z, c} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ov=%b res=%h nvzc=%b%b%b%b, want all zero",
                     out_valid, result, n, v, z, c);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_add();
        int lat;
        run_op(SEQ_ADD, 16'h00FF, 16'h0001, 1'b0, lat);
        n_checks++;
        if (lat !== 2) begin
            n_fail++;
            $display("FAIL add_latency: got %0d edges after accept, want 2", lat);
        end
        n_checks++;
        if ({result, n, v, z, c} !== {16'h0100, 4'b0000}) begin
            n_fail++;
            $display("FAIL add_result: got %h nvzc=%b%b%b%b want 0100 nvzc=0000", result, n, v, z, c);
        end
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL add_in_ready_done: got %b want 0", in_ready);
        end
        finish_op();
        run_op(SEQ_ADD, 16'h7FFF, 16'h0001, 1'b0, lat);
        n_checks++;
        if ({result, n, v, z, c} !== {16'h8000, 4'b1100}) begin
            n_fail++;
            $display("FAIL add_overflow: got %h nvzc=%b%b%b%b want 8000 nvzc=1100", result, n, v, z, c);
        end
        finish_op();
    endtask

    task automatic test_sub();
        int lat;
        run_op(SEQ_SUB, 16'h8000, 16'h0001, 1'b1, lat);
        n_checks++;
        if ({result, n, v, z, c} !== {16'h7FFF, 4'b0101}) begin
            n_fail++;
            $display("FAIL sub_result: got %h nvzc=%b%b%b%b want 7fff nvzc=0101", result, n, v, z, c);
        end
        finish_op();
    endtask

    task automatic test_cmp_shr();
        int lat;
        run_op(SEQ_CMP, 16'h1234, 16'h1234, 1'b0, lat);
        n_checks++;
        if ({n, v, z, c} !== 4'b0011) begin
            n_fail++;
            $display("FAIL cmp_flags: got nvzc=%b%b%b%b want 0011", n, v, z, c);
        end
        finish_op();
        run_op(SEQ_SHR, 16'h0001, 16'h0000, 1'b1, lat);
        n_checks++;
        if ({result, n, v, z, c} !== {16'h8000, 4'b1001}) begin
            n_fail++;
            $display("FAIL shr_result: got %h nvzc=%b%b%b%b want 8000 nvzc=1001", result, n, v, z, c);
        end
        finish_op();
        run_op(SEQ_SHR, 16'h8100, 16'h0000, 1'b0, lat);
        n_checks++;
        if ({result, n, v, z, c} !== {16'h4080, 4'b0000}) begin
            n_fail++;
            $display("FAIL shr_cross_byte: got %h nvzc=%b%b%b%b want 4080 nvzc=0000", result, n, v, z, c);
        end
        finish_op();
    endtask

    task automatic test_shl_logic();
        int lat;
        run_op(SEQ_SHL, 16'h8000, 16'h0000, 1'b0, lat);
        n_checks++;
        if ({result, n, v, z, c} !== {16'h0000, 4'b0011}) begin
            n_fail++;
            $display("FAIL shl_result: got %h nvzc=%b%b%b%b want 0000 nvzc=0011", result, n, v, z, c);
        end
        finish_op();
        run_op(SEQ_SHL, 16'h0080, 16'hFFFF, 1'b1, lat);
        n_checks++;
        if ({result, n, v, z, c} !== {16'h0101, 4'b0000}) begin
            n_fail++;
            $display("FAIL shl_cross_byte: got %h nvzc=%b%b%b%b want 0101 nvzc=0000", result, n, v, z, c);
        end
        finish_op();
        run_op(SEQ_XOR, 16'hFF00, 16'h0FF0, 1'b1, lat);
        n_checks++;
        if ({result, n, v, z, c} !== {16'hF0F0, 4'b1000}) begin
            n_fail++;
            $display("FAIL xor_result: got %h nvzc=%b%b%b%b want f0f0 nvzc=1000", result, n, v, z, c);
        end
        finish_op();
        run_op(SEQ_AND, 16'hF0F0, 16'h3C3C, 1'b1, lat);
        n_checks++;
        if ({result, n, v, z, c} !== {16'h3030, 4'b0000}) begin
            n_fail++;
            $display("FAIL and_result: got %h nvzc=%b%b%b%b want 3030 nvzc=0000", result, n, v, z, c);
        end
        finish_op();
        run_op(SEQ_OR, 16'hF0F0, 16'h0C0C, 1'b0, lat);
        n_checks++;
        if ({result, n, v, z, c} !== {16'hFCFC, 4'b1000}) begin
            n_fail++;
            $display("FAIL or_result: got %h nvzc=%b%b%b%b want fcfc nvzc=1000", result, n, v, z, c);
        end
        finish_op();
    endtask

    task automatic test_backpressure();
        int lat;
        run_op(SEQ_ADD, 16'h1234, 16'h1111, 1'b1, lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; op = SEQ_SUB; a = 16'hFFFF; b = 16'h0001; ci = 1'b0;
            @(posedge clk);
            #1;
            n_checks++;
            if ({out_valid, in_ready, result, n, v, z, c} !== {1'b1, 1'b0, 16'h2346, 4'b0000}) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: got ov=%b ir=%b res=%h nvzc=%b%b%b%b want ov=1 ir=0 2346 0000",
                         i, out_valid, in_ready, result, n, v, z, c);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL release_to_idle: got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_midop();
        int lat;
        @(negedge clk);
        in_valid = 1'b1; op = SEQ_ADD; a = 16'hFFFF; b = 16'h0001; ci = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, result} !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_in_second: got ov=%b res=%h want ov=0 res=0000", out_valid, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(SEQ_ADD, 16'h0001, 16'h0001, 1'b0, lat);
        n_checks++;
        if ({lat[3:0], result, n, v, z, c} !== {4'd2, 16'h0002, 4'b0000}) begin
            n_fail++;
            $display("FAIL add_after_reset: got lat=%0d %h nvzc=%b%b%b%b want lat=2 0002 nvzc=0000",
                     lat, result, n, v, z, c);
        end
        finish_op();
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_cmp_shr();
        test_shl_logic();
        test_backpressure();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
